rrg_job_sequencer: RTL and testbench

- Controller in front of the realtime ramp generator's command-register interface (reg_control, reg_0..reg_3).
- Accepts complete ramp jobs (dataset index, Yset, Rset, RIset, ROset, activate flag) from two requesters (host bus, timing-event path) and arbitrates between them round-robin.
- Serialises each granted job into the generator's command sequence: WRITE_YSET, WRITE_RSET, WRITE_RISET, WRITE_ROSET, UPDATE, and optionally SW_DATASET.
- Removes the need for software to hand-sequence the five or six register writes, and prevents interleaved writes from the two sources.

---
 rtl/rrg_job_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_rrg_job_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rrg_job_sequencer.sv
// Job sequencer for the realtime ramp generator: arbitrates whole ramp jobs from two
// requesters and serialises each one into the command/register write sequence.
module rrg_job_sequencer #(
  parameter int NR_DATASETS = 2,
  parameter int HOLD_CYCLES = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [15:0]  req_dataset,
  input  logic [127:0] req_yset,
  input  logic [127:0] req_rset,
  input  logic [127:0] req_riset,
  input  logic [127:0] req_roset,
  input  logic [1:0]   req_activate,
  output logic [15:0]  reg_control,
  output logic [15:0]  reg_0,
  output logic [15:0]  reg_1,
  output logic [15:0]  reg_2,
  output logic [15:0]  reg_3,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         grant_id
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] CODE_YSET = 8'd1;

  state_t      r_state;
  logic        r_last_grant;
  logic        r_grant_id;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        r_activate;
  logic [7:0]  r_dataset;
  logic [7:0]  r_hold;
  logic [2:0]  r_step;
  logic [63:0] r_yset;
  logic [63:0] r_rset;
  logic [63:0] r_riset;
  logic [63:0] r_roset;
  logic [15:0] r_control;
  logic [63:0] r_value;

  logic [1:0]  w_grant;
  logic        w_gidx;
  logic        w_fire;
  logic        w_bad;
  logic        w_last_step;
  logic [2:0]  w_next_step;
  logic [7:0]  w_next_code;
  logic [7:0]  w_sel_dataset;
  logic [63:0] w_sel_yset;
  logic [63:0] w_sel_rset;
  logic [63:0] w_sel_riset;
  logic [63:0] w_sel_roset;
  logic        w_sel_activate;

  // Steps 0..3 carry a set value; UPDATE and SW_DATASET carry zero.
  function automatic logic [63:0] step_value(
    input logic [2:0]  s,
    input logic [63:0] y,
    input logic [63:0] r,
    input logic [63:0] ri,
    input logic [63:0] ro
  );
    logic [63:0] v;
    case (s)
      3'd0:    v = y;
      3'd1:    v = r;
      3'd2:    v = ri;
      3'd3:    v = ro;
      default: v = 64'd0;
    endcase
    return v;
  endfunction

  // Round-robin: on a tie the requester that did not win last time is chosen.
  always_comb begin
    w_grant = 2'b00;
    case (req_valid)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
      default: w_grant = 2'b00;
    endcase
  end

  assign req_ready = (r_state == S_IDLE) ? w_grant : 2'b00;
  assign w_gidx    = w_grant[1];
  assign w_fire    = |(req_valid & req_ready);

  assign w_sel_dataset  = w_gidx ? req_dataset[15:8]    : req_dataset[7:0];
  assign w_sel_yset     = w_gidx ? req_yset[127:64]     : req_yset[63:0];
  assign w_sel_rset     = w_gidx ? req_rset[127:64]     : req_rset[63:0];
  assign w_sel_riset    = w_gidx ? req_riset[127:64]    : req_riset[63:0];
  assign w_sel_roset    = w_gidx ? req_roset[127:64]    : req_roset[63:0];
  assign w_sel_activate = w_gidx ? req_activate[1]      : req_activate[0];
  assign w_bad          = ({24'd0, w_sel_dataset} >= $unsigned(NR_DATASETS));

  assign w_last_step = r_activate ? (r_step == 3'd5) : (r_step == 3'd4);
  assign w_next_step = r_step + 3'd1;
  assign w_next_code = {5'd0, w_next_step} + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_activate   <= 1'b0;
      r_dataset    <= 8'd0;
      r_hold       <= 8'd0;
      r_step       <= 3'd0;
      r_yset       <= 64'd0;
      r_rset       <= 64'd0;
      r_riset      <= 64'd0;
      r_roset      <= 64'd0;
      r_control    <= 16'd0;
      r_value      <= 64'd0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            r_grant_id   <= w_gidx;
            r_last_grant <= w_gidx;
            if (w_bad) begin
              // Out-of-range dataset: consume the job but issue nothing.
              r_err <= 1'b1;
            end else begin
              r_dataset  <= w_sel_dataset;
              r_yset     <= w_sel_yset;
              r_rset     <= w_sel_rset;
              r_riset    <= w_sel_riset;
              r_roset    <= w_sel_roset;
              r_activate <= w_sel_activate;
              r_step     <= 3'd0;
              r_hold     <= 8'd0;
              r_busy     <= 1'b1;
              r_control  <= {w_sel_dataset, CODE_YSET};
              r_value    <= w_sel_yset;
              r_state    <= S_CMD;
            end
          end
        end
        S_CMD: begin
          if (r_hold == HOLD_LAST) begin
            r_control <= 16'd0;
            r_value   <= 64'd0;
            r_done    <= w_last_step;
            r_state   <= S_GAP;
          end else begin
            r_hold <= r_hold + 8'd1;
          end
        end
        S_GAP: begin
          if (w_last_step) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_step    <= w_next_step;
            r_hold    <= 8'd0;
            r_control <= {r_dataset, w_next_code};
            r_value   <= step_value(w_next_step, r_yset, r_rset, r_riset, r_roset);
            r_state   <= S_CMD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign reg_control = r_control;
  assign reg_0       = r_value[15:0];
  assign reg_1       = r_value[31:16];
  assign reg_2       = r_value[47:32];
  assign reg_3       = r_value[63:48];
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign grant_id    = r_grant_id;

endmodule

// File: tb/tb_rrg_job_sequencer.sv
// Bench for rrg_job_sequencer: two instances (hold 1 and hold 3) fed the same jobs,
// each checked every cycle against a trace-level model of the command sequence.
module tb_rrg_job_sequencer;

  localparam int NR = 2;

  typedef struct packed {
    logic [15:0] ctrl;
    logic [63:0] val;
    logic        busy;
    logic        done;
  } exp_t;

  localparam logic [15:0] LIT0 [1:11] = '{16'h0101, 16'h0000, 16'h0102, 16'h0000,
                                          16'h0103, 16'h0000, 16'h0104, 16'h0000,
                                          16'h0105, 16'h0000, 16'h0000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   vld [2];
  logic         rst [2];
  logic [15:0]  ds;
  logic [127:0] ys, rs, ris, ros;
  logic [1:0]   act;

  logic [1:0]   rdy [2];
  logic [15:0]  ctrl_o [2];
  logic [15:0]  r0_o [2];
  logic [15:0]  r1_o [2];
  logic [15:0]  r2_o [2];
  logic [15:0]  r3_o [2];
  logic         busy_o [2];
  logic         done_o [2];
  logic         err_o [2];
  logic         gid_o [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    rrg_job_sequencer #(.NR_DATASETS(NR), .HOLD_CYCLES(gi == 0 ? 1 : 3)) dut (
      .clk(clk), .reset(rst[gi]),
      .req_valid(vld[gi]), .req_ready(rdy[gi]),
      .req_dataset(ds), .req_yset(ys), .req_rset(rs), .req_riset(ris), .req_roset(ros),
      .req_activate(act),
      .reg_control(ctrl_o[gi]), .reg_0(r0_o[gi]), .reg_1(r1_o[gi]), .reg_2(r2_o[gi]),
      .reg_3(r3_o[gi]), .busy(busy_o[gi]), .done(done_o[gi]), .err(err_o[gi]),
      .grant_id(gid_o[gi])
    );
  end

  int   checks = 0;
  int   errors = 0;
  logic chk_en = 1'b0;
  logic tmo_flag = 1'b0;

  exp_t mq [2][$];
  logic m_last [2];
  logic m_gid [2];
  logic m_err [2];
  logic prev_rst [2];
  int   job_cnt [2] = '{0, 0};
  int   off [2] = '{0, 0};

  function automatic logic [1:0] arb(input logic [1:0] v, input logic last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t got=%h want=%h", nm, inst, $time, got, want);
    end
  endtask

  // Expected per-cycle trace of a job: each step held for the hold count, then a gap.
  task automatic build(input int i, input logic [7:0] d, input logic [63:0] y, input logic [63:0] r,
                       input logic [63:0] ri, input logic [63:0] ro, input logic a);
    int   nsteps;
    int   hold;
    exp_t e;
    logic [63:0] vals [6];
    vals   = '{y, r, ri, ro, 64'd0, 64'd0};
    nsteps = a ? 6 : 5;
    hold   = (i == 0) ? 1 : 3;
    for (int s = 0; s < nsteps; s++) begin
      for (int h = 0; h < hold; h++) begin
        e.ctrl = {d, 8'(s + 1)};
        e.val  = vals[s];
        e.busy = 1'b1;
        e.done = 1'b0;
        mq[i].push_back(e);
      end
      e.ctrl = 16'd0;
      e.val  = 64'd0;
      e.busy = 1'b1;
      e.done = (s == nsteps - 1);
      mq[i].push_back(e);
    end
  endtask

  exp_t        cur;
  logic [1:0]  erdy;
  logic [1:0]  fire;
  logic [7:0]  dsel;
  int          g;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      cur  = (mq[i].size() > 0) ? mq[i][0] : '0;
      erdy = (mq[i].size() == 0) ? arb(vld[i], m_last[i]) : 2'b00;
      if (chk_en) begin
        chk("req_ready",   i, 64'(rdy[i]), 64'(erdy));
        chk("reg_control", i, 64'(ctrl_o[i]), 64'(cur.ctrl));
        chk("reg_value",   i, {r3_o[i], r2_o[i], r1_o[i], r0_o[i]}, cur.val);
        chk("busy",        i, 64'(busy_o[i]), 64'(cur.busy));
        chk("done",        i, 64'(done_o[i]), 64'(cur.done));
        chk("err",         i, 64'(err_o[i]), 64'(m_err[i]));
        chk("grant_id",    i, 64'(gid_o[i]), 64'(m_gid[i]));
        chk("busy_ready_excl", i, 64'(busy_o[i] & (|rdy[i])), 64'd0);
        if (prev_rst[i]) begin
          chk("rst_abort_ctrl", i, 64'(ctrl_o[i]), 64'h0);
          chk("rst_abort_busy", i, 64'(busy_o[i]), 64'h0);
          chk("rst_abort_done", i, 64'(done_o[i]), 64'h0);
        end
        // Hand-computed pins for the first two jobs.
        if (i == 0 && job_cnt[0] == 1 && off[0] >= 1 && off[0] <= 11) begin
          chk("lit_ctrl", 0, 64'(ctrl_o[0]), 64'(LIT0[off[0]]));
          chk("lit_done", 0, 64'(done_o[0]), (off[0] == 10) ? 64'd1 : 64'd0);
          chk("lit_busy", 0, 64'(busy_o[0]), (off[0] <= 10) ? 64'd1 : 64'd0);
          if (off[0] == 1) begin
            chk("lit_reg2", 0, 64'(r2_o[0]), 64'h1234);
            chk("lit_reg3", 0, 64'(r3_o[0]), 64'h0000);
          end
        end
        if (i == 1 && job_cnt[1] == 1) begin
          case (off[1])
            3:  chk("lit_h3_ctrl", 1, 64'(ctrl_o[1]), 64'h0101);
            4:  chk("lit_h3_gap",  1, 64'(ctrl_o[1]), 64'h0000);
            5:  chk("lit_h3_ctrl", 1, 64'(ctrl_o[1]), 64'h0102);
            19: chk("lit_h3_ctrl", 1, 64'(ctrl_o[1]), 64'h0105);
            20: chk("lit_h3_done", 1, 64'(done_o[1]), 64'h1);
            21: chk("lit_h3_busy", 1, 64'(busy_o[1]), 64'h0);
            default: ;
          endcase
        end
        if (i == 0 && job_cnt[0] == 2) begin
          case (off[0])
            9:  chk("lit_upd_val", 0, {r3_o[0], r2_o[0], r1_o[0], r0_o[0]}, 64'h0);
            11: chk("lit_sw_ctrl", 0, 64'(ctrl_o[0]), 64'h0106);
            12: chk("lit_sw_done", 0, 64'(done_o[0]), 64'h1);
            default: ;
          endcase
        end
      end
      prev_rst[i] = rst[i];
      if (rst[i]) begin
        mq[i].delete();
        m_last[i] = 1'b1;
        m_gid[i]  = 1'b0;
        m_err[i]  = 1'b0;
        off[i]++;
      end else begin
        if (mq[i].size() > 0) void'(mq[i].pop_front());
        m_err[i] = 1'b0;
        fire = vld[i] & erdy;
        if (fire != 2'b00) begin
          g         = fire[1] ? 1 : 0;
          m_last[i] = fire[1];
          m_gid[i]  = fire[1];
          dsel      = ds[g*8 +: 8];
          if (chk_en)
            $display("inst%0d t=%0t accept req%0d ds=%0d act=%0b", i, $time, g, dsel, act[g]);
          if (int'(dsel) >= NR) begin
            m_err[i] = 1'b1;
            off[i]++;
          end else begin
            build(i, dsel, ys[g*64 +: 64], rs[g*64 +: 64], ris[g*64 +: 64], ros[g*64 +: 64], act[g]);
            job_cnt[i]++;
            off[i] = 1;
          end
        end else begin
          off[i]++;
        end
      end
    end
    if (chk_en) chk("timeout", 0, 64'(tmo_flag), 64'd0);
  end

  task automatic tick();
    logic [1:0] hs0, hs1;
    @(negedge clk);
    hs0 = vld[0] & rdy[0] & {2{~rst[0]}};
    hs1 = vld[1] & rdy[1] & {2{~rst[1]}};
    @(posedge clk);
    #1;
    vld[0] = vld[0] & ~hs0;
    vld[1] = vld[1] & ~hs1;
  endtask

  task automatic post(input int r, input logic [7:0] d, input logic [63:0] y, input logic [63:0] rr,
                      input logic [63:0] ri, input logic [63:0] ro, input logic a);
    ds[r*8 +: 8]   = d;
    ys[r*64 +: 64] = y;
    rs[r*64 +: 64] = rr;
    ris[r*64 +: 64] = ri;
    ros[r*64 +: 64] = ro;
    act[r]    = a;
    vld[0][r] = 1'b1;
    vld[1][r] = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((vld[0] | vld[1]) != 2'b00 || busy_o[0] || busy_o[1]) begin
      tick();
      n++;
      if (n > budget) begin
        tmo_flag = 1'b1;
        vld[0] = 2'b00;
        vld[1] = 2'b00;
        break;
      end
    end
    tick();
    tick();
  endtask

  initial begin
    int       n;
    bit [1:0] hit;
    vld[0] = 2'b00; vld[1] = 2'b00;
    rst[0] = 1'b1;  rst[1] = 1'b1;
    ds = '0; ys = '0; rs = '0; ris = '0; ros = '0; act = '0;
    repeat (3) tick();
    rst[0] = 1'b0; rst[1] = 1'b0;
    chk_en = 1'b1;
    tick();

    // Single job on requester 0, no activate.
    post(0, 8'd1, 64'h0000_1234_0000_0000, 64'h0000_0000_0000_00A5,
         64'h0000_0000_0001_0000, 64'hFFFF_FFFF_FFFF_FF00, 1'b0);
    wait_idle(200);

    // Same dataset with activate: SW_DATASET appended.
    post(0, 8'd1, 64'h8000_0000_0000_0001, 64'h0123_4567_89AB_CDEF,
         64'h0000_0000_0000_0007, 64'h0000_0000_0000_0009, 1'b1);
    wait_idle(200);

    // Out-of-range dataset on requester 1.
    post(1, 8'd2, 64'h1111_1111_1111_1111, 64'h2, 64'h3, 64'h4, 1'b0);
    wait_idle(50);

    // Both requesters valid together, two rounds: grants alternate.
    for (int k = 0; k < 2; k++) begin
      post(0, 8'd0, 64'hA000_0000_0000_0000 + 64'(k), 64'h10 + 64'(k), 64'h20, 64'h30, 1'b0);
      post(1, 8'd1, 64'hB000_0000_0000_0000 + 64'(k), 64'h40 + 64'(k), 64'h50, 64'h60, 1'b1);
      wait_idle(400);
    end

    // Reset asserted while ROSET is on the outputs, then a fresh tie.
    post(0, 8'd1, 64'hCAFE_0000_0000_BEEF, 64'h5, 64'h6, 64'h7, 1'b1);
    hit = 2'b00;
    n   = 0;
    while (!(hit == 2'b11 && !rst[0] && !rst[1])) begin
      tick();
      n++;
      for (int i = 0; i < 2; i++) begin
        if (rst[i]) rst[i] = 1'b0;
        else if (!hit[i] && ctrl_o[i][7:0] == 8'd4) begin
          rst[i] = 1'b1;
          hit[i] = 1'b1;
        end
      end
      if (n > 200) begin
        tmo_flag = 1'b1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        break;
      end
    end
    tick();
    post(0, 8'd0, 64'h0000_0000_0000_0055, 64'h1, 64'h2, 64'h3, 1'b0);
    post(1, 8'd1, 64'h0000_0000_0000_0066, 64'h4, 64'h5, 64'h6, 1'b0);
    wait_idle(400);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
